// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, the counterpart of the team's UART transmitter.
//
// Frame: start (0), `width` data bits LSB-first, optional parity, stop (1).
// Each bit lasts PRESCALE clocks. Three samples are taken around mid-bit (edges M-1, M, M+1,
// M = PRESCALE/2) and the bit value is their majority, decided at edge M+1.
//
// Parameters:
//   width     - data bits per frame
//   PRESCALE  - clocks per serial bit (even, >= 4)
//
// Ports:
//   CLK          - clock, rising edge
//   Reset        - synchronous active-high reset
//   Rx_in        - serial line, idles high, already synchronised
//   Parity_EN    - frame carries a parity bit (latched at start detection)
//   Parity_type  - 0 even / 1 odd parity (latched at start detection)
//   Data         - last correctly received byte
//   Data_valid   - one-cycle pulse when Data is updated
//   Parity_error - one-cycle pulse on received parity mismatch
//   Stop_error   - one-cycle pulse when the stop bit is sampled 0
module uart_rx #(
  parameter int unsigned width    = 8,
  parameter int unsigned PRESCALE = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Rx_in,
  input  logic             Parity_EN,
  input  logic             Parity_type,
  output logic [width-1:0] Data,
  output logic             Data_valid,
  output logic             Parity_error,
  output logic             Stop_error
);

  // Counter widths and the fixed edge positions within a bit.
  localparam int unsigned EdgeW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BitW  = (width > 1) ? $clog2(width) : 1;

  localparam logic [EdgeW-1:0] EdgeLo   = EdgeW'(PRESCALE / 2 - 1);
  localparam logic [EdgeW-1:0] EdgeMid  = EdgeW'(PRESCALE / 2);
  localparam logic [EdgeW-1:0] EdgeHi   = EdgeW'(PRESCALE / 2 + 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(PRESCALE - 1);
  localparam logic [EdgeW-1:0] EdgeOne  = EdgeW'(1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(width - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // Frame control state.
  state_e            state_q, state_d;
  logic [EdgeW-1:0]  edge_q, edge_d;
  logic [BitW-1:0]   bit_q, bit_d;

  // Early samples of the current bit: [0] at edge M-1, [1] at edge M.
  logic [1:0]        samp_q, samp_d;

  // Received data, assembled LSB-first.
  logic [width-1:0]  shift_q, shift_d;

  // Frame format captured at start detection, plus the parity mismatch flag.
  logic              par_en_q, par_en_d;
  logic              par_type_q, par_type_d;
  logic              mism_q, mism_d;

  // Registered outputs.
  logic [width-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              serr_q, serr_d;

  // Decision helpers.
  logic              maj;
  logic              edge_wrap;
  logic              decide;
  logic              par_exp;
  logic [width:0]    shift_ext;

  // The third sample is the live line value at edge M+1, so the vote is complete
  // in the same cycle the decision is taken.
  assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & Rx_in) | (samp_q[1] & Rx_in);
  assign edge_wrap = (edge_q == EdgeLast);
  assign decide    = (edge_q == EdgeHi);

  // Expected parity bit of the assembled data.
  assign par_exp   = (^shift_q) ^ par_type_q;

  // New bit enters at the MSB and moves down, so the first bit ends in bit 0.
  assign shift_ext = {maj, shift_q};

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    mism_d     = mism_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;

    // Bit timing and the two early samples run in every in-frame state.
    if (state_q != StIdle) begin
      edge_d = edge_wrap ? '0 : edge_q + 1'b1;
      if (edge_q == EdgeLo) begin
        samp_d[0] = Rx_in;
      end
      if (edge_q == EdgeMid) begin
        samp_d[1] = Rx_in;
      end
    end

    unique case (state_q)
      StIdle: begin
        // The detect cycle is edge 0 of the start bit.
        if (!Rx_in) begin
          state_d    = StStart;
          edge_d     = EdgeOne;
          bit_d      = '0;
          par_en_d   = Parity_EN;
          par_type_d = Parity_type;
          mism_d     = 1'b0;
        end
      end

      StStart: begin
        // For PRESCALE = 4 the decision edge is also the last edge; glitch wins.
        if (decide && maj) begin
          state_d = StIdle;
          edge_d  = '0;
        end else if (edge_wrap) begin
          state_d = StData;
          bit_d   = '0;
        end
      end

      StData: begin
        if (decide) begin
          shift_d = shift_ext[width:1];
        end
        if (edge_wrap) begin
          if (bit_q == BitLast) begin
            state_d = par_en_q ? StParity : StStop;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      StParity: begin
        if (decide) begin
          mism_d = (maj != par_exp);
        end
        if (edge_wrap) begin
          state_d = StStop;
        end
      end

      StStop: begin
        // Decide mid-stop-bit and return to idle at once so a following start
        // edge at the nominal frame boundary is not missed.
        if (decide) begin
          state_d = StIdle;
          edge_d  = '0;
          serr_d  = ~maj;
          perr_d  = mism_q;
          if (maj && !mism_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= StIdle;
      edge_q     <= '0;
      bit_q      <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      mism_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      mism_q     <= mism_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  assign Data         = data_q;
  assign Data_valid   = valid_q;
  assign Parity_error = perr_q;
  assign Stop_error   = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx (width = 8, PRESCALE = 8). Directed frames are driven serially;
// each frame's expected strobe (kind, Data value, cycle) is queued when the frame starts,
// and an independent monitor pops and compares whenever the DUT raises any strobe.
module tb_uart_rx;

  localparam int unsigned Pre = 8;
  localparam int unsigned Mid = Pre / 2;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       par_en;
  logic       par_type;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic       v;
    logic       pe;
    logic       se;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  uart_rx #(
    .width   (8),
    .PRESCALE(Pre)
  ) dut (
    .CLK         (clk),
    .Reset       (rst),
    .Rx_in       (rx),
    .Parity_EN   (par_en),
    .Parity_type (par_type),
    .Data        (data),
    .Data_valid  (data_valid),
    .Parity_error(parity_error),
    .Stop_error  (stop_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue one expected strobe, lat cycles after the current cycle (first low sample).
  task automatic expect_evt(input logic v, input logic pe, input logic se,
                            input logic [7:0] d, input int lat);
    exp_t e;
    e.v    = v;
    e.pe   = pe;
    e.se   = se;
    e.data = d;
    e.cyc  = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame. pbit is the literal parity bit sent; noise flips the sample at edge
  // Mid of every bit; rst_bit >= 0 pulses Reset at edge 0 of that bit and abandons the frame.
  // Format inputs are inverted right after start detection; they must have no effect.
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptype,
                            input bit pbit, input bit stopb, input bit noise,
                            input int rst_bit);
    logic [10:0] bits;
    int          nb;
    nb   = pen ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pen) bits[9] = pbit;
    bits[nb-1] = stopb;
    par_en   = pen;
    par_type = ptype;
    for (int b = 0; b < nb; b++) begin
      for (int e = 0; e < Pre; e++) begin
        if (b == rst_bit && e == 0) rst = 1'b1;
        rx = (noise && e == Mid) ? ~bits[b] : bits[b];
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (b == rst_bit) begin
          rx = 1'b1;
          return;
        end
        if (b == 0 && e == 0) begin
          par_en   = ~pen;
          par_type = ~ptype;
        end
      end
    end
    rx = 1'b1;
  endtask

  // Monitor: every strobe must match the head of the scoreboard, in the right cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (data_valid || parity_error || stop_error) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got v=%0b pe=%0b se=%0b data=0x%0h expected none (cycle %0d)",
                   data_valid, parity_error, stop_error, data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("data_valid", int'(data_valid), int'(e.v));
          check("parity_error", int'(parity_error), int'(e.pe));
          check("stop_error", int'(stop_error), int'(e.se));
          check("data", int'(data), int'(e.data));
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_strobe: got none expected v=%0b pe=%0b se=%0b data=0x%0h at cycle %0d",
                 e.v, e.pe, e.se, e.data, e.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    par_en   = 1'b0;
    par_type = 1'b0;

    // Reset held with the line toggling: nothing may come out.
    for (int i = 0; i < 24; i++) begin
      rx = i[1];
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    @(negedge clk);
    check("reset_data", int'(data), 0);
    check("reset_valid", int'(data_valid), 0);
    check("reset_perr", int'(parity_error), 0);
    check("reset_serr", int'(stop_error), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);

    // 0x55, even parity, parity bit 0: good frame at t0+86.
    expect_evt(1'b1, 1'b0, 1'b0, 8'h55, 86);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);

    // Back-to-back: 0xAA odd parity with parity bit 0 (wrong), then 0xCA without parity.
    expect_evt(1'b0, 1'b1, 1'b0, 8'h55, 86);
    send_frame(8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    expect_evt(1'b1, 1'b0, 1'b0, 8'hCA, 78);
    send_frame(8'hCA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle(5);

    // Stop bit driven 0 on 0x3C: stop error, Data held at 0xCA.
    expect_evt(1'b0, 1'b0, 1'b1, 8'hCA, 78);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(40);

    // Glitch: 3 low cycles, then idle; then a good 0x96 with odd parity (parity bit 1).
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(30);
    @(negedge clk);
    check("data_after_glitch", int'(data), 8'hCA);
    @(posedge clk);
    #1;
    expect_evt(1'b1, 1'b0, 1'b0, 8'h96, 86);
    send_frame(8'h96, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    idle(20);

    // Reset at data bit 4 of 0x81: frame abandoned, Data cleared.
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    idle(20);
    @(negedge clk);
    check("data_after_reset", int'(data), 0);
    @(posedge clk);
    #1;
    expect_evt(1'b1, 1'b0, 1'b0, 8'h81, 78);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);

    // Same byte with every edge-Mid sample inverted, even parity bit 0.
    expect_evt(1'b1, 1'b0, 1'b0, 8'h81, 86);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    idle(20);

    // 0x01 even parity sent with parity bit 0 and stop bit 0: both errors together.
    expect_evt(1'b0, 1'b1, 1'b1, 8'h81, 86);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(60);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the downstream stage of the team's UART transmitter. It samples the serial line, reconstructs frames of the form start, `width` data bits LSB-first, optional parity, stop, and presents each good byte on a parallel bus with a one-cycle valid strobe. Frame format and parity convention match the transmitter exactly. Each bit is oversampled `PRESCALE` times with majority vote, so the line may come from a transmitter running at CLK/`PRESCALE` bit rate.

## Interface
Parameters:
- `width`, 8: data bits per frame.
- `PRESCALE`, 8: CLK cycles per serial bit. Legal values are even and ≥ 4.

Ports:
- `CLK`, in, 1: single clock; all logic is on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `Rx_in`, in, 1: serial line; idles high. Already synchronised upstream.
- `Parity_EN`, in, 1: 1 means the frame carries a parity bit.
- `Parity_type`, in, 1: 0 selects even parity, 1 selects odd.
- `Data`, out, `width`: last correctly received byte.
- `Data_valid`, out, 1: one-cycle pulse when `Data` is updated.
- `Parity_error`, out, 1: one-cycle pulse when the received parity is wrong.
- `Stop_error`, out, 1: one-cycle pulse when the stop bit is sampled 0.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Counters:**
  - `edge_cnt` runs 0..`PRESCALE`-1 within each bit.
  - `bit_cnt` runs 0..`width`-1 in DATA.
- **Sample points:** edges M-1, M and M+1, where M = `PRESCALE`/2. The bit value is the majority of those three samples. The decision is taken at edge M+1.
- **IDLE:**
  - When `Rx_in`=0, go to START. That detect cycle counts as edge 0, so the next cycle is edge 1.
  - At detection, latch `Parity_EN` and `Parity_type` for the whole frame.
- **START:**
  - At edge M+1, if the majority is 1, treat it as a glitch: return to IDLE with no output.
  - Otherwise, at edge `PRESCALE`-1, go to DATA with `bit_cnt`=0.
- **DATA:**
  - At each decision, shift the bit into the shift register LSB-first.
  - At edge `PRESCALE`-1 of bit `width`-1, go to PARITY if the latched enable is 1, else go to STOP.
- **PARITY:**
  - The expected bit is XOR of the data bits, inverted when odd parity is latched.
  - Record a mismatch flag at the decision. Go to STOP at edge `PRESCALE`-1.
- **STOP:** at edge M+1 (no wait for end of bit, so back-to-back frames are tolerated):
  - Stop bit 0: pulse `Stop_error`. `Data` is unchanged.
  - Stop bit 1 and parity mismatch: pulse `Parity_error`. `Data` is unchanged.
  - Stop bit 1 and no mismatch: load `Data` from the shift register and pulse `Data_valid`.
  - If stop bit is 0 and parity also mismatched, pulse both errors.
  - In every case, go to IDLE.
- **Line in IDLE after STOP:**
  - If `Rx_in` is still 0 after a stop error, this is treated as a new start edge. This is intentional and needs no resynchronisation logic.
  - If `Rx_in` falls in the first IDLE cycle, a new frame starts.
- **Input changes:** changes to `Parity_EN` and `Parity_type` mid-frame have no effect on the current frame.

## Timing
- **Reset values:** `Data`=0, `Data_valid`=0, `Parity_error`=0, `Stop_error`=0. State is IDLE and both counters are 0.
- **Reset mid-frame:** the frame is abandoned; no strobes in the reset cycle or after it.
- **Outputs:** all registered. Each strobe is high for exactly one cycle.
- **Latency:** with t0 = the cycle `Rx_in` is first seen low and N = 1 + `width` + P + 1 bits (P = 1 with parity, else 0), the strobe is high in cycle t0 + (N-1)·`PRESCALE` + M + 2.
  - Example, `width`=8, parity on, `PRESCALE`=8: t0+86.
- **Accepted start pulse:** a low pulse on `Rx_in` shorter than M cycles never produces a strobe.

## Test plan
- **Reset:** hold `Reset`=1 with `Rx_in` toggling → all outputs 0, no strobes.
- **Good frame:** frame 0x55, even parity (parity bit 0), `PRESCALE`=8 → `Data`=0x55, `Data_valid` high only in cycle t0+86, no error strobes.
- **Back-to-back with errors:** frame 0xAA with odd parity selected and parity bit 0 sent, followed immediately by 0xCA with `Parity_EN`=0 → first frame gives `Parity_error` pulse with `Data` held at 0x55; second gives `Data`=0xCA with `Data_valid` at t0'+78.
- **Stop error:** stop bit driven 0 on frame 0x3C → `Stop_error` pulse, `Data` unchanged, `Data_valid` stays 0.
- **Glitch rejection:** `Rx_in` low for 3 cycles then high → state returns to IDLE, no strobes. A valid frame sent afterwards is received correctly.
- **Reset mid-frame and noise:**
  - `Reset` pulsed at data bit 4, then a clean 0x81 frame → only 0x81 is reported.
  - A single-cycle inverted sample at edge M of each bit → still decoded as 0x81 by majority vote.
